// File: rtl/ecat_datagram_parser.sv
// ecat_datagram_parser
//   Parses the EtherCAT payload that follows Ethernet header stripping. The
//   payload is a 2-byte frame header followed by chained datagrams. For each
//   datagram the parser:
//     - latches a stable descriptor (sub_*) for the FMMU stage;
//     - streams the data bytes together with their offsets;
//     - flags the two working-counter (WKC) bytes.
//
//   Optional build macro FRAME_LEN_CHECK_EN: counts the bytes that follow the
//   frame header and checks the count against the header's length field.
//
// Ports
//   clk, RSTN          clock and asynchronous active-low reset
//   rx_sof/rx_eof      first/last byte of a frame, qualified by rx_valid
//   rx_valid, rx_data  payload byte stream; rx_valid=0 cycles are ignored
//   sub_cmd/sub_idx/sub_address/sub_len, subdv
//                      datagram descriptor; the fields are meaningful only
//                      while subdv=1
//   data_valid, data_byte, data_offset
//                      data-field byte strobe and its offset
//   wkc_valid, wkc_hi  WKC byte strobe (low byte first)
//   dg_done            pulse after the second WKC byte
//   frame_done         pulse when a frame ends cleanly
//   frame_err          pulse on any framing error
//
// Stream handshake: a byte is consumed on every clock where rx_valid=1; there
// is no back-pressure. Every output is registered, so each output reflects the
// byte consumed on the previous edge.
module ecat_datagram_parser #(
    parameter int LEN_W        = 8,
    parameter bit LOGICAL_ONLY = 1'b1
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             rx_sof,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_eof,
    output logic [7:0]       sub_cmd,
    output logic [7:0]       sub_idx,
    output logic [31:0]      sub_address,
    output logic [LEN_W-1:0] sub_len,
    output logic             subdv,
    output logic             data_valid,
    output logic [7:0]       data_byte,
    output logic [10:0]      data_offset,
    output logic             wkc_valid,
    output logic             wkc_hi,
    output logic             dg_done,
    output logic             frame_done,
    output logic             frame_err
);

    localparam int MAX_LEN = (LEN_W >= 11) ? 2047 : ((1 << LEN_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FHDR, S_DHDR, S_DATA, S_WKC, S_TAIL, S_SKIP
    } state_t;

    state_t             state, state_n;
    logic [10:0]        cnt, cnt_n;
    logic [7:0]         h_cmd, h_cmd_n, h_idx, h_idx_n;
    logic [31:0]        h_addr, h_addr_n;
    logic [10:0]        h_len, h_len_n;
    logic               h_more, h_more_n;
    logic [7:0]         sub_cmd_n, sub_idx_n, data_byte_n;
    logic [31:0]        sub_address_n;
    logic [LEN_W-1:0]   sub_len_n;
    logic [10:0]        data_offset_n;
    logic               subdv_n, data_valid_n, wkc_valid_n, wkc_hi_n;
    logic               dg_done_n, frame_done_n, frame_err_n;
    logic               len_ok, cmd_ok;

`ifdef FRAME_LEN_CHECK_EN
    logic [10:0]        flen, flen_n;
    logic [11:0]        fcnt, fcnt_n;
    logic [12:0]        dg_end;
    // Position just after this datagram's WKC, counted from the end of FHDR.
    assign dg_end = 13'(fcnt) + 13'(h_len) + 13'd3;
`endif

    assign len_ok = (int'(h_len) <= MAX_LEN);
    assign cmd_ok = !LOGICAL_ONLY || (h_cmd >= 8'h0A && h_cmd <= 8'h0C);

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state       <= S_IDLE;
            cnt         <= '0;
            h_cmd       <= '0;
            h_idx       <= '0;
            h_addr      <= '0;
            h_len       <= '0;
            h_more      <= 1'b0;
            sub_cmd     <= '0;
            sub_idx     <= '0;
            sub_address <= '0;
            sub_len     <= '0;
            subdv       <= 1'b0;
            data_valid  <= 1'b0;
            data_byte   <= '0;
            data_offset <= '0;
            wkc_valid   <= 1'b0;
            wkc_hi      <= 1'b0;
            dg_done     <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
`ifdef FRAME_LEN_CHECK_EN
            flen        <= '0;
            fcnt        <= '0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            h_cmd       <= h_cmd_n;
            h_idx       <= h_idx_n;
            h_addr      <= h_addr_n;
            h_len       <= h_len_n;
            h_more      <= h_more_n;
            sub_cmd     <= sub_cmd_n;
            sub_idx     <= sub_idx_n;
            sub_address <= sub_address_n;
            sub_len     <= sub_len_n;
            subdv       <= subdv_n;
            data_valid  <= data_valid_n;
            data_byte   <= data_byte_n;
            data_offset <= data_offset_n;
            wkc_valid   <= wkc_valid_n;
            wkc_hi      <= wkc_hi_n;
            dg_done     <= dg_done_n;
            frame_done  <= frame_done_n;
            frame_err   <= frame_err_n;
`ifdef FRAME_LEN_CHECK_EN
            flen        <= flen_n;
            fcnt        <= fcnt_n;
`endif
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        h_cmd_n       = h_cmd;
        h_idx_n       = h_idx;
        h_addr_n      = h_addr;
        h_len_n       = h_len;
        h_more_n      = h_more;
        sub_cmd_n     = sub_cmd;
        sub_idx_n     = sub_idx;
        sub_address_n = sub_address;
        sub_len_n     = sub_len;
        subdv_n       = subdv;
        data_byte_n   = data_byte;
        data_offset_n = data_offset;
        wkc_hi_n      = wkc_hi;
        data_valid_n  = 1'b0;
        wkc_valid_n   = 1'b0;
        dg_done_n     = 1'b0;
        frame_done_n  = 1'b0;
        frame_err_n   = 1'b0;
`ifdef FRAME_LEN_CHECK_EN
        flen_n        = flen;
        fcnt_n        = fcnt;
`endif
        if (rx_valid) begin
            if (rx_sof) begin
                // Any sof restarts parsing; it is an error unless we were idle.
                frame_err_n = (state != S_IDLE);
                state_n     = S_FHDR;
                cnt_n       = '0;
                subdv_n     = 1'b0;
`ifdef FRAME_LEN_CHECK_EN
                flen_n      = {3'b000, rx_data};
                fcnt_n      = '0;
`endif
            end else begin
                case (state)
                    S_FHDR: begin
                        if (rx_eof) begin
                            frame_err_n = 1'b1;
                            state_n     = S_IDLE;
                        end else if (rx_data[7:4] != 4'h1) begin
                            frame_err_n = 1'b1;
                            state_n     = S_SKIP;
                        end else begin
                            state_n = S_DHDR;
                            cnt_n   = '0;
`ifdef FRAME_LEN_CHECK_EN
                            flen_n[10:8] = rx_data[2:0];
`endif
                        end
                    end
                    S_DHDR: begin
`ifdef FRAME_LEN_CHECK_EN
                        fcnt_n = fcnt + 12'd1;
`endif
                        if (rx_eof) begin
                            frame_err_n = 1'b1;
                            subdv_n     = 1'b0;
                            state_n     = S_IDLE;
                        end else begin
                            cnt_n = cnt + 11'd1;
                            case (cnt[3:0])
                                4'd0: h_cmd_n         = rx_data;
                                4'd1: h_idx_n         = rx_data;
                                4'd2: h_addr_n[7:0]   = rx_data;
                                4'd3: h_addr_n[15:8]  = rx_data;
                                4'd4: h_addr_n[23:16] = rx_data;
                                4'd5: h_addr_n[31:24] = rx_data;
                                4'd6: h_len_n[7:0]    = rx_data;
                                4'd7: begin
                                    h_len_n[10:8] = rx_data[2:0];
                                    h_more_n      = rx_data[7];
                                end
                                4'd9: begin
                                    // Header complete: publish the descriptor.
                                    sub_cmd_n     = h_cmd;
                                    sub_idx_n     = h_idx;
                                    sub_address_n = h_addr;
                                    sub_len_n     = LEN_W'(h_len);
                                    subdv_n       = len_ok && cmd_ok;
                                    frame_err_n   = !len_ok;
                                    cnt_n         = '0;
                                    state_n       = (h_len == 11'd0) ? S_WKC : S_DATA;
`ifdef FRAME_LEN_CHECK_EN
                                    if (dg_end > 13'(flen)) begin
                                        frame_err_n = 1'b1;
                                        subdv_n     = 1'b0;
                                        state_n     = S_SKIP;
                                    end
`endif
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_DATA: begin
`ifdef FRAME_LEN_CHECK_EN
                        fcnt_n = fcnt + 12'd1;
`endif
                        if (rx_eof) begin
                            frame_err_n = 1'b1;
                            subdv_n     = 1'b0;
                            state_n     = S_IDLE;
                        end else begin
                            data_valid_n  = 1'b1;
                            data_byte_n   = rx_data;
                            data_offset_n = cnt;
                            if (cnt == h_len - 11'd1) begin
                                state_n = S_WKC;
                                cnt_n   = '0;
                            end else begin
                                cnt_n = cnt + 11'd1;
                            end
                        end
                    end
                    S_WKC: begin
`ifdef FRAME_LEN_CHECK_EN
                        fcnt_n = fcnt + 12'd1;
`endif
                        if (cnt == 11'd0) begin
                            if (rx_eof) begin
                                frame_err_n = 1'b1;
                                subdv_n     = 1'b0;
                                state_n     = S_IDLE;
                            end else begin
                                wkc_valid_n = 1'b1;
                                wkc_hi_n    = 1'b0;
                                cnt_n       = 11'd1;
                            end
                        end else begin
                            // Datagram complete; an eof here is only legal
                            // when no further datagram is announced.
                            wkc_valid_n = 1'b1;
                            wkc_hi_n    = 1'b1;
                            dg_done_n   = 1'b1;
                            subdv_n     = 1'b0;
                            cnt_n       = '0;
                            if (h_more) begin
                                frame_err_n = rx_eof;
                                state_n     = rx_eof ? S_IDLE : S_DHDR;
                            end else begin
                                frame_done_n = rx_eof;
                                state_n      = rx_eof ? S_IDLE : S_TAIL;
`ifdef FRAME_LEN_CHECK_EN
                                if (fcnt + 12'd1 != 12'(flen)) begin
                                    frame_done_n = 1'b0;
                                    frame_err_n  = 1'b1;
                                    state_n      = rx_eof ? S_IDLE : S_SKIP;
                                end
`endif
                            end
                        end
                    end
                    S_TAIL: begin
                        if (rx_eof) begin
                            frame_done_n = 1'b1;
                            state_n      = S_IDLE;
                        end
                    end
                    S_SKIP: begin
                        if (rx_eof) state_n = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ecat_datagram_parser.sv
module tb_ecat_datagram_parser;

  logic        clk = 1'b0;
  logic        RSTN = 1'b0;
  logic        rx_sof = 1'b0, rx_valid = 1'b0, rx_eof = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  sub_cmd, sub_idx, data_byte;
  logic [31:0] sub_address;
  logic [7:0]  sub_len;
  logic        subdv, data_valid, wkc_valid, wkc_hi, dg_done, frame_done, frame_err;
  logic [10:0] data_offset;

  ecat_datagram_parser #(.LEN_W(8), .LOGICAL_ONLY(1'b1)) dut (
    .clk(clk), .RSTN(RSTN), .rx_sof(rx_sof), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_eof(rx_eof), .sub_cmd(sub_cmd), .sub_idx(sub_idx),
    .sub_address(sub_address), .sub_len(sub_len), .subdv(subdv),
    .data_valid(data_valid), .data_byte(data_byte), .data_offset(data_offset),
    .wkc_valid(wkc_valid), .wkc_hi(wkc_hi), .dg_done(dg_done),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // observation: events seen on the DUT outputs
  logic [55:0] obs_desc_q[$];
  logic [18:0] obs_data_q[$];
  logic [0:0]  obs_wkc_q[$];
  int          obs_dg = 0, obs_fdone = 0, obs_ferr = 0, gap_viol = 0;
  logic        subdv_d = 1'b0, v_last = 1'b0;

  always @(posedge clk) v_last <= rx_valid;

  always @(negedge clk) begin
    subdv_d <= subdv;
    if (subdv && !subdv_d) obs_desc_q.push_back({sub_cmd, sub_idx, sub_address, sub_len});
    if (data_valid) obs_data_q.push_back({data_offset, data_byte});
    if (wkc_valid) obs_wkc_q.push_back(wkc_hi);
    if (dg_done) obs_dg <= obs_dg + 1;
    if (frame_done) obs_fdone <= obs_fdone + 1;
    if (frame_err) obs_ferr <= obs_ferr + 1;
    if (!v_last && (data_valid || wkc_valid || dg_done || frame_done || frame_err))
      gap_viol <= gap_viol + 1;
  end

  // scoreboard: expected events from the reference model
  logic [55:0] exp_desc_q[$];
  logic [18:0] exp_data_q[$];
  logic [0:0]  exp_wkc_q[$];
  int          exp_dg, exp_fdone, exp_ferr;
  logic [7:0]  frame_q[$];

  int checks = 0, failures = 0;
  int b_desc, b_data, b_wkc, b_dg, b_fd, b_fe;

  // frame description consumed by the model
  int          n_dg;
  logic [7:0]  g_cmd[4];
  logic [31:0] g_addr[4];
  int          g_len[4];
  bit          fixed_data;
  logic [3:0]  g_type;
  int          g_pad;
  logic [7:0]  cmd_tab[8] = '{8'h01, 8'h02, 8'h04, 8'h05, 8'h0A, 8'h0B, 8'h0C, 8'h07};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    exp_desc_q.delete();
    exp_data_q.delete();
    exp_wkc_q.delete();
    exp_dg = 0;
    exp_fdone = 0;
    exp_ferr = 0;
  endtask

  // Reference model: serialise the frame and list the events it should cause.
  task automatic build_frame();
    int flen;
    bit more;
    logic [7:0] idx, b;
    flen = 0;
    frame_q.delete();
    clear_exp();
    for (int i = 0; i < n_dg; i++) flen += 12 + g_len[i];
    frame_q.push_back(8'(flen));
    frame_q.push_back({g_type, 1'b0, 3'(flen >> 8)});
    for (int i = 0; i < n_dg; i++) begin
      more = (i < n_dg - 1);
      idx = fixed_data ? 8'(i + 1) : 8'($urandom);
      frame_q.push_back(g_cmd[i]);
      frame_q.push_back(idx);
      for (int k = 0; k < 4; k++) frame_q.push_back(8'(g_addr[i] >> (8 * k)));
      frame_q.push_back(8'(g_len[i]));
      frame_q.push_back({more, 4'b0000, 3'(g_len[i] >> 8)});
      frame_q.push_back(8'($urandom));
      frame_q.push_back(8'($urandom));
      if (g_len[i] <= 255 && g_cmd[i] >= 8'h0A && g_cmd[i] <= 8'h0C)
        exp_desc_q.push_back({g_cmd[i], idx, g_addr[i], 8'(g_len[i])});
      if (g_len[i] > 255) exp_ferr++;
      for (int j = 0; j < g_len[i]; j++) begin
        b = fixed_data ? 8'(8'hAA + j * 17) : 8'($urandom);
        frame_q.push_back(b);
        exp_data_q.push_back({11'(j), b});
      end
      frame_q.push_back(fixed_data ? 8'h00 : 8'($urandom));
      frame_q.push_back(fixed_data ? 8'h00 : 8'($urandom));
      exp_wkc_q.push_back(1'b0);
      exp_wkc_q.push_back(1'b1);
      exp_dg++;
    end
    for (int p = 0; p < g_pad; p++) frame_q.push_back(8'($urandom));
    exp_fdone = 1;
    if (g_type != 4'h1) begin
      clear_exp();
      exp_ferr = 1;
    end
  endtask

  // driver: bytes [start, start+count) with random idle gaps between them
  task automatic send(input int start, input int count, input bit with_sof, input bit with_eof);
    for (int i = start; i < start + count; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      rx_data  = frame_q[i];
      rx_sof   = with_sof && (i == start);
      rx_eof   = with_eof && (i == start + count - 1);
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;
    end
  endtask

  task automatic mark();
    b_desc = obs_desc_q.size();
    b_data = obs_data_q.size();
    b_wkc  = obs_wkc_q.size();
    b_dg   = obs_dg;
    b_fd   = obs_fdone;
    b_fe   = obs_ferr;
  endtask

  task automatic check_frame(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " desc_count"}, obs_desc_q.size() - b_desc, exp_desc_q.size());
    for (int i = 0; i < exp_desc_q.size(); i++)
      if (b_desc + i < obs_desc_q.size()) check({tag, " desc"}, obs_desc_q[b_desc + i], exp_desc_q[i]);
    check({tag, " data_count"}, obs_data_q.size() - b_data, exp_data_q.size());
    for (int i = 0; i < exp_data_q.size(); i++)
      if (b_data + i < obs_data_q.size()) check({tag, " data"}, obs_data_q[b_data + i], exp_data_q[i]);
    check({tag, " wkc_count"}, obs_wkc_q.size() - b_wkc, exp_wkc_q.size());
    for (int i = 0; i < exp_wkc_q.size(); i++)
      if (b_wkc + i < obs_wkc_q.size()) check({tag, " wkc_hi"}, obs_wkc_q[b_wkc + i], exp_wkc_q[i]);
    check({tag, " dg_done"}, obs_dg - b_dg, exp_dg);
    check({tag, " frame_done"}, obs_fdone - b_fd, exp_fdone);
    check({tag, " frame_err"}, obs_ferr - b_fe, exp_ferr);
    check({tag, " gap_strobes"}, gap_viol, 0);
    check({tag, " subdv_idle"}, subdv, 1'b0);
  endtask

  task automatic one_dg(input logic [7:0] cmd, input logic [31:0] addr, input int len);
    n_dg = 1;
    g_cmd[0] = cmd;
    g_addr[0] = addr;
    g_len[0] = len;
  endtask

  initial begin
    fixed_data = 1'b0;
    g_type = 4'h1;
    g_pad = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst subdv", subdv, 1'b0);
    check("rst sub_address", sub_address, 32'h0);
    check("rst sub_len", sub_len, 8'h0);
    check("rst data_valid", data_valid, 1'b0);
    check("rst data_offset", data_offset, 11'h0);
    check("rst wkc_valid", wkc_valid, 1'b0);
    check("rst dg_done", dg_done, 1'b0);
    check("rst frame_done", frame_done, 1'b0);
    check("rst frame_err", frame_err, 1'b0);
    RSTN = 1'b1;
    @(posedge clk);
    #1;

    // single LRD with fixed contents
    fixed_data = 1'b1;
    one_dg(8'h0A, 32'h0001_0000, 4);
    build_frame();
    mark();
    send(0, frame_q.size(), 1'b1, 1'b1);
    check_frame("lrd");
    check("lrd sub_address_hold", sub_address, 32'h0001_0000);
    check("lrd sub_len_hold", sub_len, 8'd4);
    fixed_data = 1'b0;

    // LWR len 2 chained to LRW len 0
    n_dg = 2;
    g_cmd[0] = 8'h0B; g_addr[0] = $urandom; g_len[0] = 2;
    g_cmd[1] = 8'h0C; g_addr[1] = $urandom; g_len[1] = 0;
    build_frame();
    mark();
    send(0, frame_q.size(), 1'b1, 1'b1);
    check_frame("chain");
    check("chain sub_cmd", sub_cmd, 8'h0C);

    // APRD: data streams, no descriptor
    one_dg(8'h01, $urandom, 3);
    g_pad = 2;
    build_frame();
    mark();
    send(0, frame_q.size(), 1'b1, 1'b1);
    check_frame("aprd");

    // oversize length
    one_dg(8'h0A, $urandom, 300);
    g_pad = 1;
    build_frame();
    mark();
    send(0, frame_q.size(), 1'b1, 1'b1);
    check_frame("len300");

    // randomized frames
    for (int f = 0; f < 16; f++) begin
      n_dg = $urandom_range(1, 3);
      for (int i = 0; i < n_dg; i++) begin
        g_cmd[i] = cmd_tab[$urandom_range(0, 7)];
        g_addr[i] = $urandom;
        g_len[i] = $urandom_range(0, 8);
      end
      g_pad = $urandom_range(0, 2);
      build_frame();
      mark();
      send(0, frame_q.size(), 1'b1, 1'b1);
      check_frame("random");
    end

    // bad frame type: whole frame skipped
    g_type = 4'h2;
    one_dg(8'h0A, $urandom, 3);
    g_pad = 0;
    build_frame();
    mark();
    send(0, frame_q.size(), 1'b1, 1'b1);
    check_frame("bad_type");
    g_type = 4'h1;

    // eof on the third data byte of four
    one_dg(8'h0A, $urandom, 4);
    build_frame();
    while (exp_data_q.size() > 2) void'(exp_data_q.pop_back());
    exp_wkc_q.delete();
    exp_dg = 0; exp_fdone = 0; exp_ferr = 1;
    mark();
    send(0, 15, 1'b1, 1'b1);
    check_frame("eof_in_data");

    // eof on second WKC byte while more=1
    n_dg = 2;
    g_cmd[0] = 8'h0B; g_addr[0] = $urandom; g_len[0] = 1;
    g_cmd[1] = 8'h0A; g_addr[1] = $urandom; g_len[1] = 2;
    build_frame();
    void'(exp_desc_q.pop_back());
    while (exp_data_q.size() > 1) void'(exp_data_q.pop_back());
    while (exp_wkc_q.size() > 2) void'(exp_wkc_q.pop_back());
    exp_dg = 1; exp_fdone = 0; exp_ferr = 1;
    mark();
    send(0, 15, 1'b1, 1'b1);
    check_frame("eof_more");

    // sof in the middle of a datagram, then a clean frame
    one_dg(8'h0B, $urandom, 4);
    build_frame();
    send(0, 13, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    one_dg(8'h0C, $urandom, 3);
    build_frame();
    exp_ferr = exp_ferr + 1;
    mark();
    send(0, frame_q.size(), 1'b1, 1'b1);
    check_frame("sof_restart");

    // reset in the data field, then bytes without sof are ignored
    one_dg(8'h0A, $urandom, 6);
    build_frame();
    send(0, 14, 1'b1, 1'b0);
    check("pre_reset subdv", subdv, 1'b1);
    #2;
    RSTN = 1'b0;
    #1;
    check("mid_reset subdv", subdv, 1'b0);
    check("mid_reset data_valid", data_valid, 1'b0);
    check("mid_reset data_offset", data_offset, 11'h0);
    check("mid_reset sub_address", sub_address, 32'h0);
    check("mid_reset sub_cmd", sub_cmd, 8'h0);
    @(posedge clk);
    #1;
    RSTN = 1'b1;
    clear_exp();
    mark();
    send(14, frame_q.size() - 14, 1'b0, 1'b1);
    check_frame("no_sof_after_reset");
    one_dg(8'h0B, $urandom, 5);
    build_frame();
    mark();
    send(0, frame_q.size(), 1'b1, 1'b1);
    check_frame("after_reset");

`ifdef FRAME_LEN_CHECK_EN
    // header length one short of the datagram size
    one_dg(8'h0A, $urandom, 4);
    build_frame();
    frame_q[0] = 8'd15;
    clear_exp();
    exp_ferr = 1;
    mark();
    send(0, frame_q.size(), 1'b1, 1'b1);
    check_frame("flen_short");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
